// File: rtl/opsum_buffer_ctrl.sv
// Sequencer for the per-row opsum FIFO buffer: fill from Reducer, pad-align on flush,
// then drain whole 16-beat groups to the GLB write port at consecutive word addresses.
module opsum_buffer_ctrl #(
  parameter int ROW_NUM = 32,
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic              red_valid,
  output logic              red_ready,
  input  logic              tile_flush,
  output logic              store_compute_f,
  output logic              read_opsum_f,
  output logic              glb_req,
  input  logic              glb_gnt,
  output logic              glb_we,
  output logic [ADDR_W-1:0] glb_waddr,
  output logic              busy,
  output logic              done
);

  localparam int BEATS  = ROW_NUM / 2;
  localparam int OCC_W  = $clog2(DEPTH + 1);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    ALIGN = 3'd2,
    REQ   = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   base;
  logic [ADDR_W-1:0]   addr_cnt;
  logic [OCC_W-1:0]    occ;
  logic [OCC_W-1:0]    grp;
  logic [OCC_W-1:0]    pad;
  logic [BEAT_W-1:0]   beat;
  logic                flushed;
  logic [OCC_W-1:0]    occ_nxt;

  // Occupancy including a same-cycle accept, so tile_flush sees the result it arrives with.
  always_comb begin
    occ_nxt = occ;
    if (red_valid) occ_nxt = occ + OCC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      base     <= '0;
      addr_cnt <= '0;
      occ      <= '0;
      grp      <= '0;
      pad      <= '0;
      beat     <= '0;
      flushed  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base     <= cfg_base_addr;
            addr_cnt <= '0;
            occ      <= '0;
            flushed  <= 1'b0;
            state    <= FILL;
          end
        end
        FILL: begin
          occ <= occ_nxt;
          if (tile_flush) begin
            if (occ_nxt == '0) begin
              state <= DONE;
            end else if (occ_nxt < OCC_W'(DEPTH)) begin
              flushed <= 1'b1;
              pad     <= OCC_W'(DEPTH) - occ_nxt;
              grp     <= occ_nxt;
              state   <= ALIGN;
            end else begin
              flushed <= 1'b1;
              grp     <= OCC_W'(DEPTH);
              state   <= REQ;
            end
          end else if (occ_nxt == OCC_W'(DEPTH)) begin
            grp   <= OCC_W'(DEPTH);
            state <= REQ;
          end
        end
        ALIGN: begin
          // Garbage shifts push the real entries down to the FIFO output stage.
          pad <= pad - OCC_W'(1);
          if (pad == OCC_W'(1)) state <= REQ;
        end
        REQ: begin
          if (glb_gnt) begin
            beat  <= '0;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          addr_cnt <= addr_cnt + ADDR_W'(1);
          if (beat == BEAT_W'(BEATS - 1)) begin
            beat <= '0;
            grp  <= grp - OCC_W'(1);
            if (grp == OCC_W'(1)) begin
              occ   <= '0;
              state <= flushed ? DONE : FILL;
            end
          end else begin
            beat <= beat + BEAT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    red_ready       = (state == FILL);
    store_compute_f = ((state == FILL) && red_valid) || (state == ALIGN);
    read_opsum_f    = (state == DRAIN);
    glb_req         = (state == REQ) || (state == DRAIN);
    glb_we          = (state == DRAIN);
    glb_waddr       = (state == DRAIN) ? (base + addr_cnt) : '0;
    busy            = (state != IDLE);
    done            = (state == DONE);
  end

endmodule

// File: tb/tb_opsum_buffer_ctrl.sv
// Directed bench for opsum_buffer_ctrl: a vector table for short state walks plus
// hand-written fill/drain/flush, delayed-grant, reset-in-drain and address-wrap sequences.
module tb_opsum_buffer_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] cfg_base_addr;
  logic        red_valid;
  logic        red_ready;
  logic        tile_flush;
  logic        store_compute_f;
  logic        read_opsum_f;
  logic        glb_req;
  logic        glb_gnt;
  logic        glb_we;
  logic [15:0] glb_waddr;
  logic        busy;
  logic        done;

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  opsum_buffer_ctrl #(.ROW_NUM(32), .DEPTH(4), .ADDR_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_base_addr(cfg_base_addr),
    .red_valid(red_valid), .red_ready(red_ready), .tile_flush(tile_flush),
    .store_compute_f(store_compute_f), .read_opsum_f(read_opsum_f),
    .glb_req(glb_req), .glb_gnt(glb_gnt), .glb_we(glb_we), .glb_waddr(glb_waddr),
    .busy(busy), .done(done)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic        st;
    logic [15:0] base;
    logic        rv;
    logic        tf;
    logic        gnt;
    logic [22:0] exp;
  } vec_t;

  // Expected outputs packed as {red_ready, store, read, req, we, busy, done, waddr}.
  function automatic logic [22:0] mk(input logic rdy, input logic st, input logic rd,
                                     input logic rq, input logic we, input logic bz,
                                     input logic dn, input logic [15:0] a);
    return {rdy, st, rd, rq, we, bz, dn, a};
  endfunction

  function automatic vec_t mkv(input string n, input logic rst, input logic st,
                               input logic [15:0] b, input logic rv, input logic tf,
                               input logic g, input logic [22:0] e);
    vec_t v;
    v.name = n; v.rst = rst; v.st = st; v.base = b;
    v.rv = rv; v.tf = tf; v.gnt = g; v.exp = e;
    return v;
  endfunction

  // Drive one cycle's inputs after the falling edge, compare settled outputs, advance.
  task automatic cyc(input string n, input logic rst, input logic st, input logic [15:0] b,
                     input logic rv, input logic tf, input logic g, input logic [22:0] e);
    logic [22:0] act;
    reset = rst; start = st; cfg_base_addr = b;
    red_valid = rv; tile_flush = tf; glb_gnt = g;
    #1;
    act = {red_ready, store_compute_f, read_opsum_f, glb_req, glb_we, busy, done, glb_waddr};
    ntot++;
    if (act !== e) $display("FAIL %s: got %h expected %h", n, act, e);
    else npass++;
    if (store_compute_f && read_opsum_f) begin
      ntot++;
      $display("FAIL %s_excl: store and read both high", n);
    end
    @(negedge clk);
  endtask

  vec_t tbl[17];
  logic [22:0] z;

  initial begin
    z = mk(0, 0, 0, 0, 0, 0, 0, 16'h0000);
    tbl[0]  = mkv("t_reset",       0, 0, 16'h0000, 0, 0, 0, z);
    tbl[1]  = mkv("t_start",       1, 1, 16'h0300, 0, 0, 0, z);
    tbl[2]  = mkv("t_fill_flush0", 1, 0, 16'h0000, 0, 1, 0, mk(1, 0, 0, 0, 0, 1, 0, 16'h0));
    tbl[3]  = mkv("t_done0",       1, 0, 16'h0000, 0, 0, 0, mk(0, 0, 0, 0, 0, 1, 1, 16'h0));
    tbl[4]  = mkv("t_idle_flush",  1, 0, 16'h0000, 0, 1, 0, z);
    tbl[5]  = mkv("t_start2",      1, 1, 16'h0300, 0, 0, 0, z);
    tbl[6]  = mkv("t_acc1",        1, 0, 16'h0000, 1, 0, 0, mk(1, 1, 0, 0, 0, 1, 0, 16'h0));
    tbl[7]  = mkv("t_novalid",     1, 0, 16'h0000, 0, 0, 0, mk(1, 0, 0, 0, 0, 1, 0, 16'h0));
    tbl[8]  = mkv("t_acc2_flush",  1, 0, 16'h0000, 1, 1, 0, mk(1, 1, 0, 0, 0, 1, 0, 16'h0));
    tbl[9]  = mkv("t_align0",      1, 0, 16'h0000, 1, 0, 0, mk(0, 1, 0, 0, 0, 1, 0, 16'h0));
    tbl[10] = mkv("t_align1",      1, 0, 16'h0000, 1, 0, 0, mk(0, 1, 0, 0, 0, 1, 0, 16'h0));
    tbl[11] = mkv("t_req_nognt",   1, 0, 16'h0000, 1, 0, 0, mk(0, 0, 0, 1, 0, 1, 0, 16'h0));
    tbl[12] = mkv("t_req_gnt",     1, 1, 16'h0000, 1, 0, 1, mk(0, 0, 0, 1, 0, 1, 0, 16'h0));
    tbl[13] = mkv("t_drain0",      1, 0, 16'h0000, 1, 0, 0, mk(0, 0, 1, 1, 1, 1, 0, 16'h0300));
    tbl[14] = mkv("t_drain1",      1, 0, 16'h0000, 0, 1, 0, mk(0, 0, 1, 1, 1, 1, 0, 16'h0301));
    tbl[15] = mkv("t_drain2_rst",  0, 0, 16'h0000, 0, 0, 0, mk(0, 0, 1, 1, 1, 1, 0, 16'h0302));
    tbl[16] = mkv("t_after_rst",   1, 0, 16'h0000, 0, 0, 0, z);

    reset = 1'b0; start = 1'b0; cfg_base_addr = '0;
    red_valid = 1'b0; tile_flush = 1'b0; glb_gnt = 1'b0;
    @(negedge clk);
    @(negedge clk);

    for (int i = 0; i < 17; i++)
      cyc(tbl[i].name, tbl[i].rst, tbl[i].st, tbl[i].base, tbl[i].rv, tbl[i].tf,
          tbl[i].gnt, tbl[i].exp);

    // Full tile, grant tied high, red_valid held through REQ/DRAIN, then partial flush.
    cyc("A_start", 1, 1, 16'h0100, 0, 0, 1, z);
    for (int i = 0; i < 4; i++) cyc("A_fill", 1, 0, 16'h0, 1, 0, 1, mk(1, 1, 0, 0, 0, 1, 0, 16'h0));
    cyc("A_req", 1, 0, 16'h0, 1, 0, 1, mk(0, 0, 0, 1, 0, 1, 0, 16'h0));
    for (int i = 0; i < 64; i++)
      cyc($sformatf("A_drain%0d", i), 1, 0, 16'h0, 1, 0, 1,
          mk(0, 0, 1, 1, 1, 1, 0, 16'(16'h0100 + i)));
    cyc("A_refill", 1, 0, 16'h0, 1, 0, 1, mk(1, 1, 0, 0, 0, 1, 0, 16'h0));
    cyc("A_flush", 1, 0, 16'h0, 1, 1, 1, mk(1, 1, 0, 0, 0, 1, 0, 16'h0));
    for (int i = 0; i < 2; i++) cyc("A_align", 1, 0, 16'h0, 0, 0, 1, mk(0, 1, 0, 0, 0, 1, 0, 16'h0));
    cyc("A_req2", 1, 0, 16'h0, 0, 0, 1, mk(0, 0, 0, 1, 0, 1, 0, 16'h0));
    for (int i = 0; i < 32; i++)
      cyc($sformatf("A_drain2_%0d", i), 1, 0, 16'h0, 0, 0, 1,
          mk(0, 0, 1, 1, 1, 1, 0, 16'(16'h0140 + i)));
    cyc("A_done", 1, 0, 16'h0, 0, 0, 1, mk(0, 0, 0, 0, 0, 1, 1, 16'h0));
    cyc("A_idle", 1, 0, 16'h0, 0, 0, 1, z);

    // Late grant, then reset in the middle of the drain.
    cyc("B_start", 1, 1, 16'h0000, 0, 0, 0, z);
    for (int i = 0; i < 4; i++) cyc("B_fill", 1, 0, 16'h0, 1, 0, 0, mk(1, 1, 0, 0, 0, 1, 0, 16'h0));
    for (int i = 0; i < 5; i++) cyc("B_wait", 1, 0, 16'h0, 0, 0, 0, mk(0, 0, 0, 1, 0, 1, 0, 16'h0));
    cyc("B_gnt", 1, 0, 16'h0, 0, 0, 1, mk(0, 0, 0, 1, 0, 1, 0, 16'h0));
    for (int i = 0; i < 7; i++)
      cyc($sformatf("B_drain%0d", i), 1, 0, 16'h0, 0, 0, 0,
          mk(0, 0, 1, 1, 1, 1, 0, 16'(i)));
    cyc("B_rst_beat7", 0, 0, 16'h0, 0, 0, 0, mk(0, 0, 1, 1, 1, 1, 0, 16'h0007));
    cyc("B_after_rst", 1, 0, 16'h0, 0, 0, 0, z);

    // Full tile flushed on its last accept, address wraps past 0xFFFF.
    cyc("C_start", 1, 1, 16'hFFF8, 0, 0, 0, z);
    for (int i = 0; i < 3; i++) cyc("C_fill", 1, 0, 16'h0, 1, 0, 0, mk(1, 1, 0, 0, 0, 1, 0, 16'h0));
    cyc("C_fill_flush", 1, 0, 16'h0, 1, 1, 0, mk(1, 1, 0, 0, 0, 1, 0, 16'h0));
    cyc("C_req", 1, 0, 16'h0, 0, 0, 1, mk(0, 0, 0, 1, 0, 1, 0, 16'h0));
    for (int i = 0; i < 64; i++)
      cyc($sformatf("C_drain%0d", i), 1, 0, 16'h0, 0, 0, 0,
          mk(0, 0, 1, 1, 1, 1, 0, 16'(16'hFFF8 + i)));
    cyc("C_done", 1, 0, 16'h0, 0, 0, 0, mk(0, 0, 0, 0, 0, 1, 1, 16'h0));
    cyc("C_idle", 1, 0, 16'h0, 0, 0, 0, z);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
